// File: rtl/cordic_vectoring_if.sv
// Handshake bundle for cordic_vectoring: Cartesian pair in, angle/magnitude out.
// The master drives inputs and out_ready; the slave (the CORDIC core) drives the rest.
interface cordic_vectoring_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x_in;
    logic [7:0] y_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] angle;
    logic [7:0] mag;

    modport master (
        output in_valid,
        output x_in,
        output y_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  angle,
        input  mag
    );

    modport slave (
        input  in_valid,
        input  x_in,
        input  y_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output angle,
        output mag
    );
endinterface

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC vectoring unit: (x,y) Q0.7 -> atan2 angle Q3.5 and gain-compensated magnitude.
// Define QUADRANT_EN to add a pre-rotation by pi, extending the angle to the full -pi..+pi range.
module cordic_vectoring #(
    parameter int unsigned Iter = 12,
    parameter int unsigned W    = 12
) (
    input logic               clk_i,
    input logic               rst_i,
    cordic_vectoring_if.slave bus
);
    localparam int unsigned ZW = W + 1;

    localparam logic [1:0] StIdle = 2'd0;
`ifdef QUADRANT_EN
    localparam logic [1:0] StPre  = 2'd1;
    localparam logic signed [ZW-1:0] ZPi = ZW'(1608);
`endif
    localparam logic [1:0] StIter = 2'd2;
    localparam logic [1:0] StOut  = 2'd3;

    localparam logic signed [ZW:0] AngHalf = (ZW+1)'(8);
    localparam logic signed [ZW:0] AngMax  = (ZW+1)'(127);
    localparam logic signed [ZW:0] AngMin  = (ZW+1)'(-128);
    localparam logic signed [W:0]  MagHalf = (W+1)'(2);
    localparam logic signed [W:0]  MagMax  = (W+1)'(255);

    logic [1:0]             state_q, state_d;
    logic [3:0]             count_q, count_d;
    logic signed [W-1:0]    x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0]   z_q, z_d;
    logic                   zero_q, zero_d;
    logic                   out_valid_q, out_valid_d;
    logic [7:0]             angle_q, angle_d;
    logic [7:0]             mag_q, mag_d;

    logic signed [W-1:0]    x_sh, y_sh, x_it, y_it;
    logic signed [ZW-1:0]   z_it;

    function automatic logic signed [ZW-1:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    atan_lut = ZW'(402);
            4'd1:    atan_lut = ZW'(237);
            4'd2:    atan_lut = ZW'(125);
            4'd3:    atan_lut = ZW'(64);
            4'd4:    atan_lut = ZW'(32);
            4'd5:    atan_lut = ZW'(16);
            4'd6:    atan_lut = ZW'(8);
            4'd7:    atan_lut = ZW'(4);
            4'd8:    atan_lut = ZW'(2);
            4'd9:    atan_lut = ZW'(1);
            4'd10:   atan_lut = ZW'(1);
            default: atan_lut = '0;
        endcase
    endfunction

    // Round half-up from Q3.9 to Q3.5, saturating to the signed 8-bit range.
    function automatic logic [7:0] angle_of(input logic signed [ZW-1:0] z);
        logic signed [ZW:0] zr;
        zr = {z[ZW-1], z};
        zr = (zr + AngHalf) >>> 4;
        if (zr > AngMax) begin
            angle_of = 8'h7F;
        end else if (zr < AngMin) begin
            angle_of = 8'h80;
        end else begin
            angle_of = 8'(zr);
        end
    endfunction

    // Multiply by ~0.6074 to undo the CORDIC gain, then round Q2.9 down to unsigned Q1.7.
    function automatic logic [7:0] mag_of(input logic signed [W-1:0] x);
        logic signed [W:0] xe;
        logic signed [W:0] xg;
        logic signed [W:0] xr;
        xe = {x[W-1], x};
        xg = (xe >>> 1) + (xe >>> 3) - (xe >>> 6) - (xe >>> 9);
        xr = (xg + MagHalf) >>> 2;
        if (xg[W]) begin
            mag_of = '0;
        end else if (xr > MagMax) begin
            mag_of = 8'hFF;
        end else begin
            mag_of = 8'(xr);
        end
    endfunction

    always_comb begin
        x_sh = x_q >>> count_q;
        y_sh = y_q >>> count_q;
        if (!y_q[W-1]) begin
            x_it = x_q + y_sh;
            y_it = y_q - x_sh;
            z_it = z_q + atan_lut(count_q);
        end else begin
            x_it = x_q - y_sh;
            y_it = y_q + x_sh;
            z_it = z_q - atan_lut(count_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        angle_d     = angle_q;
        mag_d       = mag_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    x_d     = {{(W-10){bus.x_in[7]}}, bus.x_in, 2'b00};
                    y_d     = {{(W-10){bus.y_in[7]}}, bus.y_in, 2'b00};
                    z_d     = '0;
                    count_d = '0;
                    zero_d  = (bus.x_in == 8'h00) && (bus.y_in == 8'h00);
`ifdef QUADRANT_EN
                    state_d = StPre;
`else
                    state_d = StIter;
`endif
                end
            end
`ifdef QUADRANT_EN
            StPre: begin
                // Left half-plane: rotate by pi so the iterations only see x >= 0.
                if (x_q[W-1]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = y_q[W-1] ? -ZPi : ZPi;
                end
                state_d = StIter;
            end
`endif
            StIter: begin
                x_d     = x_it;
                y_d     = y_it;
                z_d     = z_it;
                count_d = count_q + 4'd1;
                if (count_q == 4'(Iter - 1)) begin
                    state_d     = StOut;
                    out_valid_d = 1'b1;
                    // A zero vector has no defined phase; report 0 rather than the table sum.
                    angle_d     = zero_q ? 8'h00 : angle_of(z_it);
                    mag_d       = mag_of(x_it);
                end
            end
            StOut: begin
                if (bus.out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            count_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            angle_q     <= '0;
            mag_q       <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            angle_q     <= angle_d;
            mag_q       <= mag_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.angle     = angle_q;
    assign bus.mag       = mag_q;
endmodule

// File: tb/tb_cordic_vectoring.sv
// Bench for cordic_vectoring: directed cases, backpressure, mid-run reset and random pairs
// checked against an atan2/sqrt reference model.
module tb_cordic_vectoring;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    cordic_vectoring_if bus ();

    cordic_vectoring dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef QUADRANT_EN
    localparam int ExpLat    = 13;
    localparam bit FullRange = 1'b1;
`else
    localparam int ExpLat    = 12;
    localparam bit FullRange = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp, input int tol);
        int d;
        d = (obs > exp) ? obs - exp : exp - obs;
        n_cmp++;
        assert ((d <= tol) === 1'b1) else begin
            n_bad++;
            $error("FAIL %s: got %0d, expected %0d +/-%0d", tag, obs, exp, tol);
        end
    endtask

    function automatic int ref_angle(input int x, input int y);
        if (x == 0 && y == 0) return 0;
        return int'($atan2(real'(y), real'(x)) * 32.0);
    endfunction

    function automatic int ref_mag(input int x, input int y);
        return int'($sqrt(real'(x * x + y * y)));
    endfunction

    // Send one pair, wait for the result, optionally stall the consumer, then release it.
    task automatic run_pair(input int x, input int y, input int hold, input string tag,
                            output int ang, output int mag);
        int         lat;
        logic [7:0] a_cap;
        logic [7:0] m_cap;
        lat = 0;
        @(negedge clk);
        check_eq({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.x_in     = 8'(x);
        bus.y_in     = 8'(y);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check_eq({tag, " latency"}, 32'(lat), 32'(ExpLat));
        a_cap = bus.angle;
        m_cap = bus.mag;
        ang   = int'($signed(a_cap));
        mag   = int'(m_cap);
        for (int k = 0; k < hold; k++) begin
            bus.in_valid = 1'b1;
            bus.x_in     = 8'h11;
            bus.y_in     = 8'h22;
            @(posedge clk);
            #1;
            check_eq({tag, " stall"}, 32'({bus.out_valid, bus.in_ready, bus.angle, bus.mag}),
                     32'({1'b1, 1'b0, a_cap, m_cap}));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_eq({tag, " release"}, 32'({bus.out_valid, bus.in_ready, bus.angle, bus.mag}),
                 32'({1'b0, 1'b1, a_cap, m_cap}));
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int   a;
        int   m;
        logic seen_valid;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x_in      = 8'h00;
        bus.y_in      = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset state", 32'({bus.in_ready, bus.out_valid, bus.angle, bus.mag}),
                 32'({1'b1, 1'b0, 8'h00, 8'h00}));
        rst = 1'b0;

        run_pair(127, 0, 0, "east", a, m);
        check_near("east angle", a, 0, 1);
        check_near("east mag", m, 127, 1);

        run_pair(90, 90, 5, "diag+", a, m);
        check_near("diag+ angle", a, 25, 1);
        check_near("diag+ mag", m, 127, 1);

        run_pair(90, -90, 0, "diag-", a, m);
        check_near("diag- angle", a, -25, 1);
        check_near("diag- mag", m, 127, 1);

        run_pair(0, 127, 1, "north", a, m);
        check_near("north angle", a, 50, 1);
        check_near("north mag", m, 127, 1);

        run_pair(0, 0, 0, "zero", a, m);
        check_eq("zero angle", 32'(a), 32'd0);
        check_eq("zero mag", 32'(m), 32'd0);

`ifdef QUADRANT_EN
        run_pair(-90, 90, 0, "q2", a, m);
        check_near("q2 angle", a, 75, 1);
        run_pair(-128, 0, 0, "west", a, m);
        check_near("west angle", a, 100, 1);
        check_near("west mag", m, 128, 1);
`endif

        for (int t = 0; t < 30; t++) begin
            int x;
            int y;
            x = FullRange ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 127));
            y = int'($urandom_range(0, 255)) - 128;
            if (x * x + y * y < 1600) x = (x < 0) ? x - 60 : x + 60;
            run_pair(x, y, int'($urandom_range(0, 2)), "rand", a, m);
            check_near("rand angle", a, ref_angle(x, y), 1);
            check_near("rand mag", m, ref_mag(x, y), 2);
        end

        run_pair(60, 80, 0, "pre-reset", a, m);
        check_near("pre-reset mag", m, 100, 1);

        // Abandon a pair mid-iteration.
        @(negedge clk);
        bus.x_in     = 8'(100);
        bus.y_in     = 8'(40);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("mid reset", 32'({bus.in_ready, bus.out_valid, bus.angle, bus.mag}),
                 32'({1'b1, 1'b0, 8'h00, 8'h00}));
        seen_valid = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            seen_valid = seen_valid | bus.out_valid;
        end
        check_eq("abandoned pair silent", 32'(seen_valid), 32'd0);

        run_pair(-40, 100, 0, "post-reset", a, m);
        if (FullRange) check_near("post-reset angle", a, ref_angle(-40, 100), 1);
        run_pair(100, -40, 0, "post-reset2", a, m);
        check_near("post-reset2 angle", a, ref_angle(100, -40), 1);
        check_near("post-reset2 mag", m, ref_mag(100, -40), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
